// File: rtl/key_matrix_scan_if.sv
// Keypad pin and event bundle for key_matrix_scan.
// master = board/consumer side, slave = scanner.
interface key_matrix_scan_if #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int CODE_W = 4
);
  logic [ROWS-1:0]   Key_Board_Row_i;
  logic [COLS-1:0]   Key_Board_Col_o;
  logic              Key_flag;
  logic [CODE_W-1:0] Key_Code;
  logic              Key_Multi;
  logic              Key_Held;

  modport master (
    output Key_Board_Row_i,
    input  Key_Board_Col_o, Key_flag, Key_Code, Key_Multi, Key_Held
  );

  modport slave (
    input  Key_Board_Row_i,
    output Key_Board_Col_o, Key_flag, Key_Code, Key_Multi, Key_Held
  );
endinterface

// File: rtl/key_matrix_scan.sv
// Debounced ROWS x COLS keypad scanner with single-key decode and multi-key flag.
// Optional auto-repeat of Key_flag while a single key is held: define KEY_REPEAT_EN.
module key_matrix_scan #(
  parameter int ROWS          = 4,
  parameter int COLS          = 4,
  parameter int DEBOUNCE_CYC  = 1000000,
  parameter int SETTLE_CYC    = 4,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic                Clk,
  input  logic                Rst_n,
  key_matrix_scan_if.slave    kb
);
  localparam int CODE_W = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1;
  localparam int CNT_W  = $clog2(DEBOUNCE_CYC);
  localparam int SCNT_W = $clog2(SETTLE_CYC + 1);
  localparam int COL_W  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int POP_W  = $clog2(ROWS * COLS + 1);

  typedef enum logic [2:0] {IDLE, P_FILTER, SCAN, RESULT, WAIT_R, R_FILTER} state_t;

  state_t                      state_q, state_d;
  logic [ROWS-1:0]             row_s1_q, row_s_q;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [SCNT_W-1:0]           scnt_q, scnt_d;
  logic [COL_W-1:0]            cidx_q, cidx_d;
  logic [COLS-1:0]             col_q, col_d;
  logic [COLS-1:0][ROWS-1:0]   hit_q, hit_d;
  logic [CODE_W-1:0]           code_q, code_d, hit_code;
  logic                        flag_q, flag_d, multi_q, multi_d, held_q, held_d;
  logic [POP_W-1:0]            hits;
  logic                        pressed, released, deb_done, settle_done, last_col;

`ifdef KEY_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  logic [RPT_W-1:0] rpt_q, rpt_d;
  logic             rpt_run_q, rpt_run_d, single_q, single_d;
`endif

  assign pressed     = ~&row_s_q;
  assign released    = &row_s_q;
  assign deb_done    = (cnt_q == CNT_W'(DEBOUNCE_CYC - 1));
  assign settle_done = (scnt_q == SCNT_W'(SETTLE_CYC));
  assign last_col    = (cidx_q == COL_W'(COLS - 1));

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      row_s1_q <= '1;
      row_s_q  <= '1;
    end else begin
      row_s1_q <= kb.Key_Board_Row_i;
      row_s_q  <= row_s1_q;
    end
  end

  // Popcount of the hit matrix; hit_code is meaningful only when hits == 1.
  always_comb begin
    hits     = '0;
    hit_code = '0;
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++)
        if (hit_q[c][r]) begin
          hits     = hits + POP_W'(1);
          hit_code = CODE_W'(r * COLS + c);
        end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (pressed) state_d = P_FILTER;
      P_FILTER: if (released) state_d = IDLE;
                else if (deb_done) state_d = SCAN;
      SCAN:     if (settle_done && last_col) state_d = RESULT;
      RESULT:   state_d = (hits == '0) ? IDLE : WAIT_R;
      WAIT_R:   if (released) state_d = R_FILTER;
      R_FILTER: if (released && deb_done) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    scnt_d  = scnt_q;
    cidx_d  = cidx_q;
    col_d   = col_q;
    hit_d   = hit_q;
    code_d  = code_q;
    held_d  = held_q;
    flag_d  = 1'b0;
    multi_d = 1'b0;
`ifdef KEY_REPEAT_EN
    single_d  = single_q;
    rpt_d     = '0;
    rpt_run_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        col_d = '0;
      end
      P_FILTER: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!released && deb_done) begin
          cidx_d = '0;
          scnt_d = '0;
          col_d  = ~COLS'(1);
        end
      end
      SCAN: begin
        if (settle_done) begin
          hit_d[cidx_q] = ~row_s_q;
          scnt_d        = '0;
          if (last_col) col_d = '0;
          else begin
            cidx_d = cidx_q + COL_W'(1);
            col_d  = ~(COLS'(1) << (cidx_q + COL_W'(1)));
          end
        end else begin
          scnt_d = scnt_q + SCNT_W'(1);
        end
      end
      RESULT: begin
        cnt_d = '0;
        col_d = '0;
        if (hits == POP_W'(1)) begin
          code_d = hit_code;
          flag_d = 1'b1;
          held_d = 1'b1;
        end else if (hits != '0) begin
          multi_d = 1'b1;
          held_d  = 1'b1;
        end
`ifdef KEY_REPEAT_EN
        single_d = (hits == POP_W'(1));
`endif
      end
      WAIT_R: begin
        cnt_d = '0;
`ifdef KEY_REPEAT_EN
        // First repeat after REPEAT_DELAY held cycles, then every REPEAT_PERIOD.
        if (single_q && pressed) begin
          rpt_d     = rpt_q + RPT_W'(1);
          rpt_run_d = rpt_run_q;
          if ((!rpt_run_q && rpt_q == RPT_W'(REPEAT_DELAY - 1)) ||
              ( rpt_run_q && rpt_q == RPT_W'(REPEAT_PERIOD - 1))) begin
            flag_d    = 1'b1;
            rpt_d     = '0;
            rpt_run_d = 1'b1;
          end
        end
`endif
      end
      R_FILTER: begin
        if (pressed) cnt_d = '0;
        else if (deb_done) held_d = 1'b0;
        else cnt_d = cnt_q + CNT_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      cnt_q   <= '0;
      scnt_q  <= '0;
      cidx_q  <= '0;
      col_q   <= '0;
      hit_q   <= '0;
      code_q  <= '0;
      held_q  <= 1'b0;
      flag_q  <= 1'b0;
      multi_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      scnt_q  <= scnt_d;
      cidx_q  <= cidx_d;
      col_q   <= col_d;
      hit_q   <= hit_d;
      code_q  <= code_d;
      held_q  <= held_d;
      flag_q  <= flag_d;
      multi_q <= multi_d;
    end
  end

`ifdef KEY_REPEAT_EN
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      rpt_q     <= '0;
      rpt_run_q <= 1'b0;
      single_q  <= 1'b0;
    end else begin
      rpt_q     <= rpt_d;
      rpt_run_q <= rpt_run_d;
      single_q  <= single_d;
    end
  end
`endif

  assign kb.Key_Board_Col_o = col_q;
  assign kb.Key_flag        = flag_q;
  assign kb.Key_Code        = code_q;
  assign kb.Key_Multi       = multi_q;
  assign kb.Key_Held        = held_q;
endmodule

// File: tb/tb_key_matrix_scan.sv
// Bench for key_matrix_scan: a switch-matrix model drives the rows from the held
// key set and the column drive; expected codes/latencies come from the key rules.
module tb_key_matrix_scan;
  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int DEB    = 16;
  localparam int SET    = 2;
  localparam int RD     = 50;
  localparam int RP     = 20;
  localparam int CODE_W = $clog2(ROWS * COLS);
  localparam int LAT    = 2 + DEB + COLS * (SET + 1) + 2;
`ifdef KEY_REPEAT_EN
  localparam int HOLD = LAT + 30;
`else
  localparam int HOLD = 200;
`endif

  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  always #5 Clk = ~Clk;

  key_matrix_scan_if #(.ROWS(ROWS), .COLS(COLS), .CODE_W(CODE_W)) kb_if();

  key_matrix_scan #(
    .ROWS(ROWS), .COLS(COLS), .DEBOUNCE_CYC(DEB), .SETTLE_CYC(SET),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .Clk(Clk), .Rst_n(Rst_n), .kb(kb_if)
  );

  bit keys [ROWS][COLS];
  int checks = 0;
  int errors = 0;
  int exp_code = 0;

  // A row reads low when any closed key on it sits on a selected (low) column.
  always_comb begin
    kb_if.Key_Board_Row_i = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (keys[r][c] && !kb_if.Key_Board_Col_o[c]) kb_if.Key_Board_Row_i[r] = 1'b0;
  end

  always @(negedge Clk) begin
    if (kb_if.Key_flag || kb_if.Key_Multi) begin
      checks++;
      if (kb_if.Key_flag && kb_if.Key_Multi) begin
        errors++;
        $display("FAIL excl: flag=%b multi=%b both high at %0t", kb_if.Key_flag, kb_if.Key_Multi, $time);
      end
    end
  end

  task automatic clear_keys();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) keys[r][c] = 1'b0;
  endtask

  task automatic release_check(input string tag);
    int drop = -1;
    int nf = 0;
    clear_keys();
    for (int k = 1; k <= DEB + 8; k++) begin
      @(negedge Clk);
      if (kb_if.Key_flag) nf++;
      if (drop < 0 && !kb_if.Key_Held) drop = k;
    end
    checks++;
    if (drop <= DEB || drop > DEB + 4) begin
      errors++;
      $display("FAIL %s_held_drop: dropped at cycle %0d, required %0d..%0d", tag, drop, DEB + 1, DEB + 4);
    end
    checks++;
    if (nf != 0) begin
      errors++;
      $display("FAIL %s_release_flag: %0d flags, required 0", tag, nf);
    end
    repeat (2) @(negedge Clk);
  endtask

  task automatic press_check(input int r, input int c, input string tag);
    int nf = 0;
    int at = -1;
    logic [CODE_W-1:0] got = '0;
    logic [CODE_W-1:0] want;
    want = CODE_W'(r * COLS + c);
    keys[r][c] = 1'b1;
    for (int k = 1; k <= HOLD; k++) begin
      @(negedge Clk);
      if (kb_if.Key_flag) begin
        nf++;
        if (at < 0) begin at = k; got = kb_if.Key_Code; end
      end
    end
    checks++;
    if (nf != 1) begin errors++; $display("FAIL %s_nflags: got %0d, required 1", tag, nf); end
    checks++;
    if (at != LAT) begin errors++; $display("FAIL %s_latency: got %0d, required %0d", tag, at, LAT); end
    checks++;
    if (got !== want) begin errors++; $display("FAIL %s_code: got %0d, required %0d", tag, got, want); end
    checks++;
    if (kb_if.Key_Held !== 1'b1) begin errors++; $display("FAIL %s_held: got %b, required 1", tag, kb_if.Key_Held); end
    exp_code = r * COLS + c;
    release_check(tag);
  endtask

  task automatic test_reset();
    Rst_n = 1'b0;
    repeat (2) @(negedge Clk);
    checks++; if (kb_if.Key_Board_Col_o !== '0) begin errors++; $display("FAIL rst_col: got %b, required 0", kb_if.Key_Board_Col_o); end
    checks++; if (kb_if.Key_flag !== 1'b0) begin errors++; $display("FAIL rst_flag: got %b, required 0", kb_if.Key_flag); end
    checks++; if (kb_if.Key_Multi !== 1'b0) begin errors++; $display("FAIL rst_multi: got %b, required 0", kb_if.Key_Multi); end
    checks++; if (kb_if.Key_Held !== 1'b0) begin errors++; $display("FAIL rst_held: got %b, required 0", kb_if.Key_Held); end
    checks++; if (kb_if.Key_Code !== '0) begin errors++; $display("FAIL rst_code: got %0d, required 0", kb_if.Key_Code); end
    Rst_n = 1'b1;
    exp_code = 0;
    repeat (2) @(negedge Clk);
  endtask

  task automatic test_single_key();
    press_check(2, 1, "key21");
    for (int i = 0; i < 4; i++)
      press_check(int'($urandom_range(0, ROWS - 1)), int'($urandom_range(0, COLS - 1)), "rand");
  endtask

  task automatic test_glitch();
    int nf = 0;
    int colbad = 0;
    keys[0][$urandom_range(0, COLS - 1)] = 1'b1;
    for (int k = 0; k < 45; k++) begin
      if (k == 5) clear_keys();
      @(negedge Clk);
      if (kb_if.Key_flag) nf++;
      if (kb_if.Key_Board_Col_o !== '0) colbad++;
    end
    checks++; if (nf != 0) begin errors++; $display("FAIL glitch_flag: %0d flags, required 0", nf); end
    checks++; if (colbad != 0) begin errors++; $display("FAIL glitch_col: %0d cycles col!=0, required 0", colbad); end
    checks++; if (kb_if.Key_Held !== 1'b0) begin errors++; $display("FAIL glitch_held: got %b, required 0", kb_if.Key_Held); end
  endtask

  task automatic test_multi();
    int nf = 0;
    int nm = 0;
    keys[0][0] = 1'b1;
    keys[3][3] = 1'b1;
    for (int k = 1; k <= HOLD; k++) begin
      @(negedge Clk);
      if (kb_if.Key_flag) nf++;
      if (kb_if.Key_Multi) nm++;
    end
    checks++; if (nm != 1) begin errors++; $display("FAIL multi_pulses: got %0d, required 1", nm); end
    checks++; if (nf != 0) begin errors++; $display("FAIL multi_flag: got %0d, required 0", nf); end
    checks++; if (kb_if.Key_Code !== CODE_W'(exp_code)) begin errors++; $display("FAIL multi_code: got %0d, required %0d", kb_if.Key_Code, exp_code); end
    checks++; if (kb_if.Key_Held !== 1'b1) begin errors++; $display("FAIL multi_held: got %b, required 1", kb_if.Key_Held); end
    release_check("multi");
  endtask

  task automatic test_release_bounce();
    int r = int'($urandom_range(0, ROWS - 1));
    int c = int'($urandom_range(0, COLS - 1));
    int nf = 0;
    int held_lo = 0;
    keys[r][c] = 1'b1;
    for (int k = 1; k <= HOLD; k++) begin
      @(negedge Clk);
      if (kb_if.Key_flag) nf++;
    end
    keys[r][c] = 1'b0;
    for (int k = 0; k < 11; k++) begin
      if (k == 8) keys[r][c] = 1'b1;
      @(negedge Clk);
      if (kb_if.Key_flag) nf++;
      if (!kb_if.Key_Held) held_lo++;
    end
    checks++; if (nf != 1) begin errors++; $display("FAIL bounce_nflags: got %0d, required 1", nf); end
    checks++; if (held_lo != 0) begin errors++; $display("FAIL bounce_held: low %0d cycles during bounce, required 0", held_lo); end
    checks++; if (kb_if.Key_Code !== CODE_W'(r * COLS + c)) begin errors++; $display("FAIL bounce_code: got %0d, required %0d", kb_if.Key_Code, r * COLS + c); end
    exp_code = r * COLS + c;
    release_check("bounce");
  endtask

  task automatic test_reset_scan();
    int waited = 0;
    int nf = 0;
    keys[1][2] = 1'b1;
    while (kb_if.Key_Board_Col_o === '0 && waited < 100) begin
      @(negedge Clk);
      waited++;
    end
    checks++;
    if (waited >= 100) begin errors++; $display("FAIL rscan_timeout: scan not seen in %0d cycles", waited); end
    Rst_n = 1'b0;
    @(negedge Clk);
    Rst_n = 1'b1;
    checks++; if (kb_if.Key_Board_Col_o !== '0) begin errors++; $display("FAIL rscan_col: got %b, required 0", kb_if.Key_Board_Col_o); end
    checks++; if (kb_if.Key_flag !== 1'b0) begin errors++; $display("FAIL rscan_flag: got %b, required 0", kb_if.Key_flag); end
    checks++; if (kb_if.Key_Held !== 1'b0) begin errors++; $display("FAIL rscan_held: got %b, required 0", kb_if.Key_Held); end
    checks++; if (kb_if.Key_Code !== '0) begin errors++; $display("FAIL rscan_code: got %0d, required 0", kb_if.Key_Code); end
    exp_code = 0;
    clear_keys();
    for (int k = 0; k < 40; k++) begin
      @(negedge Clk);
      if (kb_if.Key_flag) nf++;
    end
    checks++; if (nf != 0) begin errors++; $display("FAIL rscan_noflag: got %0d, required 0", nf); end
    press_check(int'($urandom_range(0, ROWS - 1)), int'($urandom_range(0, COLS - 1)), "after_rst");
  endtask

`ifdef KEY_REPEAT_EN
  task automatic test_repeat();
    int times[$];
    int want [5];
    want = '{LAT, LAT + RD, LAT + RD + RP, LAT + RD + 2 * RP, LAT + RD + 3 * RP};
    keys[1][3] = 1'b1;
    for (int k = 1; k <= LAT + 120; k++) begin
      @(negedge Clk);
      if (kb_if.Key_flag) begin
        times.push_back(k);
        checks++;
        if (kb_if.Key_Code !== CODE_W'(7)) begin errors++; $display("FAIL rpt_code: got %0d, required 7", kb_if.Key_Code); end
      end
    end
    checks++;
    if (times.size() != 5) begin errors++; $display("FAIL rpt_count: got %0d, required 5", times.size()); end
    for (int i = 0; i < 5 && i < times.size(); i++) begin
      checks++;
      if (times[i] != want[i]) begin errors++; $display("FAIL rpt_time%0d: got %0d, required %0d", i, times[i], want[i]); end
    end
    exp_code = 7;
    release_check("rpt");
  endtask
`endif

  initial begin
    clear_keys();
    test_reset();
    test_single_key();
    test_glitch();
    test_multi();
    test_release_bounce();
    test_reset_scan();
`ifdef KEY_REPEAT_EN
    test_repeat();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
